multicycle_control_unit: RTL and testbench

- Multi-cycle sequencer and decoder for the RV32I core; replaces the single-cycle combinational decoder.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with ready/req handshakes to instruction and data memory.
- Registers all datapath controls and produces write-enable pulses.
- Adds memory timeout fault, a retired-instruction counter and parametrised control widths.

---
 rtl/rv_ctrl_pkg.sv | 55 +++++
 rtl/rv_decode.sv | 92 +++++++++
 rtl/multicycle_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, control field
// codes, FSM states and the decoded-control bundle passed from rv_decode to the FSM.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;

   localparam logic [2:0] IMM_R = 3'd0;
   localparam logic [2:0] IMM_I = 3'd1;
   localparam logic [2:0] IMM_S = 3'd2;
   localparam logic [2:0] IMM_B = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;
   localparam logic [2:0] IMM_U = 3'd5;

   localparam logic [1:0] RD_ALU = 2'b00;
   localparam logic [1:0] RD_MEM = 2'b01;
   localparam logic [1:0] RD_PC4 = 2'b10;

   localparam logic [2:0] BR_NONE   = 3'b010;
   localparam logic [2:0] BR_ALWAYS = 3'b011;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b1001;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, FAULT, TRAP
   } state_e;

   typedef struct packed {
      logic [2:0] imm_type;
      logic [3:0] alu_op;
      logic       alu_a_src;
      logic       alu_b_src;
      logic [1:0] rd_src;
      logic [2:0] branch_cond;
      logic [2:0] data_size;
      logic       is_load;
      logic       is_store;
      logic       wr_rd;
      logic       illegal;
   } ctrl_t;

   // Codes 010 and 011 are the "none"/"always" markers; every other funct3 is a real compare.
   function automatic logic is_cond_branch(input logic [2:0] cond);
      return (cond != BR_NONE) && (cond != BR_ALWAYS);
   endfunction

endpackage

// File: rtl/rv_decode.sv
// Purely combinational RV32I decoder: instruction register to control bundle.
// Unknown opcodes decode as an R-type add and raise the illegal flag.
module rv_decode
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] i_ir,
   output ctrl_t       o_ctrl
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_f7b5;
   logic       w_rd_nz;
   logic       w_unused_bits;

   assign w_opcode      = i_ir[6:0];
   assign w_funct3      = i_ir[14:12];
   assign w_f7b5        = i_ir[30];
   assign w_rd_nz       = (i_ir[11:7] != 5'd0);
   assign w_unused_bits = ^{i_ir[31], i_ir[29:15]};

   always_comb begin
      o_ctrl             = '0;
      o_ctrl.branch_cond = BR_NONE;
      o_ctrl.wr_rd       = w_rd_nz;
      case (w_opcode)
         OP_IMM: begin
            o_ctrl.imm_type  = IMM_I;
            o_ctrl.alu_op    = {(w_funct3 == 3'b101) & w_f7b5, w_funct3};
            o_ctrl.alu_b_src = 1'b1;
         end
         OP: begin
            o_ctrl.imm_type = IMM_R;
            o_ctrl.alu_op   = {w_f7b5, w_funct3};
         end
         LOAD: begin
            o_ctrl.imm_type  = IMM_I;
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_b_src = 1'b1;
            o_ctrl.rd_src    = RD_MEM;
            o_ctrl.data_size = w_funct3;
            o_ctrl.is_load   = 1'b1;
         end
         STORE: begin
            o_ctrl.imm_type  = IMM_S;
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_b_src = 1'b1;
            o_ctrl.data_size = w_funct3;
            o_ctrl.is_store  = 1'b1;
            o_ctrl.wr_rd     = 1'b0;
         end
         LUI: begin
            o_ctrl.imm_type  = IMM_U;
            o_ctrl.alu_op    = ALU_PASS_B;
            o_ctrl.alu_b_src = 1'b1;
         end
         AUIPC: begin
            o_ctrl.imm_type  = IMM_U;
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_a_src = 1'b1;
            o_ctrl.alu_b_src = 1'b1;
         end
         JAL: begin
            o_ctrl.imm_type    = IMM_J;
            o_ctrl.alu_op      = ALU_ADD;
            o_ctrl.alu_a_src   = 1'b1;
            o_ctrl.alu_b_src   = 1'b1;
            o_ctrl.rd_src      = RD_PC4;
            o_ctrl.branch_cond = BR_ALWAYS;
         end
         JALR: begin
            o_ctrl.imm_type    = IMM_I;
            o_ctrl.alu_op      = ALU_ADD;
            o_ctrl.alu_b_src   = 1'b1;
            o_ctrl.rd_src      = RD_PC4;
            o_ctrl.branch_cond = BR_ALWAYS;
         end
         BRANCH: begin
            o_ctrl.imm_type    = IMM_B;
            o_ctrl.alu_op      = ALU_ADD;
            o_ctrl.alu_a_src   = 1'b1;
            o_ctrl.alu_b_src   = 1'b1;
            o_ctrl.branch_cond = w_funct3;
            o_ctrl.wr_rd       = 1'b0;
         end
         default: begin
            o_ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// timeout fault and retire counter. Define ILLEGAL_INSN_TRAP_EN to trap unknown opcodes.
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_OP_W    = 4,
   parameter int IMM_TYPE_W  = 3,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_ready,
   input  logic [31:0]           instr,
   input  logic                  dmem_ready,
   input  logic                  branch_taken,
   output logic                  imem_req,
   output logic                  dmem_req,
   output logic                  data_read_en,
   output logic                  data_write_en,
   output logic [2:0]            data_size,
   output logic [IMM_TYPE_W-1:0] imm_type,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic                  alu_a_src,
   output logic                  alu_b_src,
   output logic [1:0]            rd_src,
   output logic [2:0]            branch_cond,
   output logic                  ir_write_en,
   output logic                  reg_write_en,
   output logic                  pc_write_en,
   output logic                  pc_src,
   output logic [CNT_W-1:0]      instret,
`ifdef ILLEGAL_INSN_TRAP_EN
   output logic                  illegal_insn,
`endif
   output logic                  fault
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_e                r_state;
   state_e                w_next;
   logic [31:0]           r_ir;
   logic [WAIT_W-1:0]     r_wait;
   logic [CNT_W-1:0]      r_instret;
   logic [IMM_TYPE_W-1:0] r_imm_type;
   logic [ALU_OP_W-1:0]   r_alu_op;
   logic                  r_alu_a_src;
   logic                  r_alu_b_src;
   logic [1:0]            r_rd_src;
   logic [2:0]            r_branch_cond;
   logic [2:0]            r_data_size;
   logic                  r_is_load;
   logic                  r_is_store;
   logic                  r_wr_rd;
   ctrl_t                 w_ctrl;
   logic                  w_wait_expired;
   logic                  w_trap;

   rv_decode u_decode (
      .i_ir   (r_ir),
      .o_ctrl (w_ctrl)
   );

`ifdef ILLEGAL_INSN_TRAP_EN
   assign w_trap = w_ctrl.illegal;
`else
   logic w_unused_illegal;
   assign w_trap           = 1'b0;
   assign w_unused_illegal = w_ctrl.illegal;
`endif

   // A ready arriving on the limit cycle wins, since ready is tested before expiry.
   assign w_wait_expired = (MEM_TIMEOUT > 0) && (r_wait == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH: begin
            if (imem_ready)          w_next = DECODE;
            else if (w_wait_expired) w_next = FAULT;
         end
         DECODE:  w_next = w_trap ? TRAP : EXEC;
         EXEC:    w_next = (r_is_load || r_is_store) ? MEM : WB;
         MEM: begin
            if (dmem_ready)          w_next = r_is_store ? FETCH : WB;
            else if (w_wait_expired) w_next = FAULT;
         end
         WB:      w_next = FETCH;
         FAULT:   w_next = FAULT;
         TRAP:    w_next = TRAP;
         default: w_next = FETCH;
      endcase
   end

   // Enables are gated by rst so a mid-operation reset suppresses any pulse that cycle.
   always_comb begin
      imem_req      = 1'b0;
      ir_write_en   = 1'b0;
      dmem_req      = 1'b0;
      data_read_en  = 1'b0;
      data_write_en = 1'b0;
      reg_write_en  = 1'b0;
      pc_write_en   = 1'b0;
      pc_src        = 1'b0;
      fault         = 1'b0;
`ifdef ILLEGAL_INSN_TRAP_EN
      illegal_insn  = 1'b0;
`endif
      if (!rst) begin
         case (r_state)
            FETCH: begin
               imem_req    = 1'b1;
               ir_write_en = imem_ready;
            end
            MEM: begin
               dmem_req      = 1'b1;
               data_read_en  = r_is_load;
               data_write_en = r_is_store;
               pc_write_en   = dmem_ready && r_is_store;
            end
            WB: begin
               reg_write_en = r_wr_rd;
               pc_write_en  = 1'b1;
               pc_src       = (r_branch_cond == BR_ALWAYS) ||
                              (is_cond_branch(r_branch_cond) && branch_taken);
            end
            FAULT:   fault = 1'b1;
`ifdef ILLEGAL_INSN_TRAP_EN
            TRAP:    illegal_insn = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ir_write_en) r_ir <= instr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait <= '0;
      end else if ((r_state == FETCH && !imem_ready) || (r_state == MEM && !dmem_ready)) begin
         r_wait <= r_wait + WAIT_W'(1);
      end else begin
         r_wait <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)              r_instret <= '0;
      else if (pc_write_en) r_instret <= r_instret + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_imm_type    <= '0;
         r_alu_op      <= '0;
         r_alu_a_src   <= 1'b0;
         r_alu_b_src   <= 1'b0;
         r_rd_src      <= RD_ALU;
         r_branch_cond <= BR_NONE;
         r_data_size   <= 3'd0;
         r_is_load     <= 1'b0;
         r_is_store    <= 1'b0;
         r_wr_rd       <= 1'b0;
      end else if (r_state == DECODE) begin
         r_imm_type    <= IMM_TYPE_W'(w_ctrl.imm_type);
         r_alu_op      <= ALU_OP_W'(w_ctrl.alu_op);
         r_alu_a_src   <= w_ctrl.alu_a_src;
         r_alu_b_src   <= w_ctrl.alu_b_src;
         r_rd_src      <= w_ctrl.rd_src;
         r_branch_cond <= w_ctrl.branch_cond;
         r_data_size   <= w_ctrl.data_size;
         r_is_load     <= w_ctrl.is_load;
         r_is_store    <= w_ctrl.is_store;
         r_wr_rd       <= w_ctrl.wr_rd;
      end
   end

   assign instret     = r_instret;
   assign imm_type    = r_imm_type;
   assign alu_op      = r_alu_op;
   assign alu_a_src   = r_alu_a_src;
   assign alu_b_src   = r_alu_b_src;
   assign rd_src      = r_rd_src;
   assign branch_cond = r_branch_cond;
   assign data_size   = r_data_size;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4, CNT_W=4): a decode/latency
// vector table plus hand sequences for wait states, timeout, mid-operation reset and bad opcodes.
module tb_multicycle_control_unit;

   localparam int NV = 14;

   typedef struct {
      logic [31:0] instr;
      logic        taken;
      int          lat;
      logic        rwe;
      logic        pcs;
      logic [2:0]  imm;
      logic [3:0]  alu;
      logic        a;
      logic        b;
      logic [1:0]  rds;
      logic [2:0]  cond;
      logic [2:0]  dsz;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        imem_ready;
   logic [31:0] instr;
   logic        dmem_ready;
   logic        branch_taken;
   logic        imem_req;
   logic        dmem_req;
   logic        data_read_en;
   logic        data_write_en;
   logic [2:0]  data_size;
   logic [2:0]  imm_type;
   logic [3:0]  alu_op;
   logic        alu_a_src;
   logic        alu_b_src;
   logic [1:0]  rd_src;
   logic [2:0]  branch_cond;
   logic        ir_write_en;
   logic        reg_write_en;
   logic        pc_write_en;
   logic        pc_src;
   logic [3:0]  instret;
   logic        fault;
`ifdef ILLEGAL_INSN_TRAP_EN
   logic        illegal_insn;
`endif

   int   n_checks;
   int   n_fail;
   int   exp_instret;
   vec_t vecs [NV];
   vec_t v_ill;

   multicycle_control_unit #(
      .ALU_OP_W    (4),
      .IMM_TYPE_W  (3),
      .MEM_TIMEOUT (4),
      .CNT_W       (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_ready    (imem_ready),
      .instr         (instr),
      .dmem_ready    (dmem_ready),
      .branch_taken  (branch_taken),
      .imem_req      (imem_req),
      .dmem_req      (dmem_req),
      .data_read_en  (data_read_en),
      .data_write_en (data_write_en),
      .data_size     (data_size),
      .imm_type      (imm_type),
      .alu_op        (alu_op),
      .alu_a_src     (alu_a_src),
      .alu_b_src     (alu_b_src),
      .rd_src        (rd_src),
      .branch_cond   (branch_cond),
      .ir_write_en   (ir_write_en),
      .reg_write_en  (reg_write_en),
      .pc_write_en   (pc_write_en),
      .pc_src        (pc_src),
      .instret       (instret),
`ifdef ILLEGAL_INSN_TRAP_EN
      .illegal_insn  (illegal_insn),
`endif
      .fault         (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Starts at the beginning of a FETCH cycle, zero-wait memory, ends at the next FETCH.
   task automatic run_insn(input vec_t v, input string tag);
      bit done;
      bit rwe_seen;
      int lat;
      done = 1'b0;
      rwe_seen = 1'b0;
      lat = 0;
      instr = v.instr;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      branch_taken = v.taken;
      for (int c = 1; c <= 8; c++) begin
         if (!done) begin
            @(negedge clk);
            if (c == 1) begin
               chk({tag, ".imem_req"}, 32'(imem_req), 32'd1);
               chk({tag, ".ir_write_en"}, 32'(ir_write_en), 32'd1);
            end
            if (reg_write_en) rwe_seen = 1'b1;
            if (pc_write_en) begin
               done = 1'b1;
               lat = c;
               chk({tag, ".pc_src"}, 32'(pc_src), 32'(v.pcs));
               chk({tag, ".imm_type"}, 32'(imm_type), 32'(v.imm));
               chk({tag, ".alu_op"}, 32'(alu_op), 32'(v.alu));
               chk({tag, ".alu_a_src"}, 32'(alu_a_src), 32'(v.a));
               chk({tag, ".alu_b_src"}, 32'(alu_b_src), 32'(v.b));
               chk({tag, ".rd_src"}, 32'(rd_src), 32'(v.rds));
               chk({tag, ".branch_cond"}, 32'(branch_cond), 32'(v.cond));
               chk({tag, ".data_size"}, 32'(data_size), 32'(v.dsz));
            end
            next_cyc();
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(v.lat));
      chk({tag, ".reg_write_en"}, 32'(rwe_seen), 32'(v.rwe));
      exp_instret = (exp_instret + 1) % 16;
      chk({tag, ".instret"}, 32'(instret), 32'(exp_instret));
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      exp_instret = 0;
      //           instr          tk    lat rwe   pcs   imm   alu    a     b     rds   cond  dsz
      vecs[0]  = '{32'h00500093, 1'b0, 4, 1'b1, 1'b0, 3'd1, 4'd0,  1'b0, 1'b1, 2'd0, 3'd2, 3'd0}; // addi x1,x0,5
      vecs[1]  = '{32'h4020D193, 1'b0, 4, 1'b1, 1'b0, 3'd1, 4'd13, 1'b0, 1'b1, 2'd0, 3'd2, 3'd0}; // srai
      vecs[2]  = '{32'h4000F193, 1'b0, 4, 1'b1, 1'b0, 3'd1, 4'd7,  1'b0, 1'b1, 2'd0, 3'd2, 3'd0}; // andi, bit30 set
      vecs[3]  = '{32'h407302B3, 1'b1, 4, 1'b1, 1'b0, 3'd0, 4'd8,  1'b0, 1'b0, 2'd0, 3'd2, 3'd0}; // sub
      vecs[4]  = '{32'h00208033, 1'b0, 4, 1'b0, 1'b0, 3'd0, 4'd0,  1'b0, 1'b0, 2'd0, 3'd2, 3'd0}; // add x0
      vecs[5]  = '{32'h12345237, 1'b0, 4, 1'b1, 1'b0, 3'd5, 4'd9,  1'b0, 1'b1, 2'd0, 3'd2, 3'd0}; // lui
      vecs[6]  = '{32'h00001317, 1'b0, 4, 1'b1, 1'b0, 3'd5, 4'd0,  1'b1, 1'b1, 2'd0, 3'd2, 3'd0}; // auipc
      vecs[7]  = '{32'h008000EF, 1'b0, 4, 1'b1, 1'b1, 3'd4, 4'd0,  1'b1, 1'b1, 2'd2, 3'd3, 3'd0}; // jal x1
      vecs[8]  = '{32'h00008067, 1'b0, 4, 1'b0, 1'b1, 3'd1, 4'd0,  1'b0, 1'b1, 2'd2, 3'd3, 3'd0}; // jalr x0
      vecs[9]  = '{32'h00208463, 1'b1, 4, 1'b0, 1'b1, 3'd3, 4'd0,  1'b1, 1'b1, 2'd0, 3'd0, 3'd0}; // beq taken
      vecs[10] = '{32'h00208463, 1'b0, 4, 1'b0, 1'b0, 3'd3, 4'd0,  1'b1, 1'b1, 2'd0, 3'd0, 3'd0}; // beq not taken
      vecs[11] = '{32'h00209463, 1'b0, 4, 1'b0, 1'b0, 3'd3, 4'd0,  1'b1, 1'b1, 2'd0, 3'd1, 3'd0}; // bne not taken
      vecs[12] = '{32'h0020A423, 1'b0, 4, 1'b0, 1'b0, 3'd2, 4'd0,  1'b0, 1'b1, 2'd0, 3'd2, 3'd2}; // sw
      vecs[13] = '{32'h0040A103, 1'b0, 5, 1'b1, 1'b0, 3'd1, 4'd0,  1'b0, 1'b1, 2'd1, 3'd2, 3'd2}; // lw
      v_ill    = '{32'h000000FF, 1'b0, 4, 1'b1, 1'b0, 3'd0, 4'd0,  1'b0, 1'b0, 2'd0, 3'd2, 3'd0}; // opcode 7F

      rst = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      branch_taken = 1'b0;
      instr = vecs[0].instr;
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("rst.imem_req", 32'(imem_req), 32'd0);
      chk("rst.ir_write_en", 32'(ir_write_en), 32'd0);
      chk("rst.pc_write_en", 32'(pc_write_en), 32'd0);
      chk("rst.branch_cond", 32'(branch_cond), 32'd2);
      chk("rst.alu_op", 32'(alu_op), 32'd0);
      chk("rst.instret", 32'(instret), 32'd0);
      chk("rst.fault", 32'(fault), 32'd0);
      next_cyc();
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_insn(vecs[i], $sformatf("vec%0d", i));
      end

      // Load with three wait cycles on the data side.
      instr = vecs[13].instr;
      imem_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         dmem_ready = (c == 7);
         @(negedge clk);
         chk($sformatf("lw_wait.dmem_req c%0d", c), 32'(dmem_req), 32'(c >= 4 && c <= 7));
         chk($sformatf("lw_wait.read_en c%0d", c), 32'(data_read_en), 32'(c >= 4 && c <= 7));
         chk($sformatf("lw_wait.reg_we c%0d", c), 32'(reg_write_en), 32'(c == 8));
         if (c == 8) begin
            chk("lw_wait.rd_src", 32'(rd_src), 32'd1);
            chk("lw_wait.data_size", 32'(data_size), 32'd2);
            chk("lw_wait.write_en", 32'(data_write_en), 32'd0);
         end
         next_cyc();
      end
      exp_instret = (exp_instret + 1) % 16;
      chk("lw_wait.instret", 32'(instret), 32'(exp_instret));

      // Instruction arrives exactly on the timeout limit cycle.
      instr = vecs[0].instr;
      dmem_ready = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         imem_ready = (c >= 4);
         @(negedge clk);
         chk($sformatf("late_if.ir_we c%0d", c), 32'(ir_write_en), 32'(c == 4));
         chk($sformatf("late_if.fault c%0d", c), 32'(fault), 32'd0);
         chk($sformatf("late_if.pc_we c%0d", c), 32'(pc_write_en), 32'(c == 7));
         next_cyc();
      end
      exp_instret = (exp_instret + 1) % 16;
      chk("late_if.instret", 32'(instret), 32'(exp_instret));

      // Enough retirements to wrap the 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         run_insn(vecs[0], $sformatf("wrap%0d", i));
      end

      // Reset while a store waits in MEM.
      instr = vecs[12].instr;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 4) begin
            chk("sw_rst.dmem_req", 32'(dmem_req), 32'd1);
            chk("sw_rst.write_en", 32'(data_write_en), 32'd1);
            chk("sw_rst.read_en", 32'(data_read_en), 32'd0);
         end
         next_cyc();
      end
      rst = 1'b1;
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("sw_rst.pc_we", 32'(pc_write_en), 32'd0);
      chk("sw_rst.dmem_req_in_rst", 32'(dmem_req), 32'd0);
      next_cyc();
      rst = 1'b0;
      exp_instret = 0;

      // Fetch that never completes: fault after four request cycles.
      instr = vecs[0].instr;
      imem_ready = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) chk("sw_rst.instret", 32'(instret), 32'(exp_instret));
         chk($sformatf("timeout.imem_req c%0d", c), 32'(imem_req), 32'(c <= 4));
         chk($sformatf("timeout.fault c%0d", c), 32'(fault), 32'(c >= 5));
         next_cyc();
      end
      rst = 1'b1;
      @(negedge clk);
      chk("timeout.fault_in_rst", 32'(fault), 32'd0);
      chk("timeout.imem_req_in_rst", 32'(imem_req), 32'd0);
      next_cyc();
      rst = 1'b0;

`ifdef ILLEGAL_INSN_TRAP_EN
      instr = v_ill.instr;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) chk("trap.ir_write_en", 32'(ir_write_en), 32'd1);
         chk($sformatf("trap.illegal c%0d", c), 32'(illegal_insn), 32'(c >= 3));
         if (c >= 3) begin
            chk($sformatf("trap.imem_req c%0d", c), 32'(imem_req), 32'd0);
            chk($sformatf("trap.dmem_req c%0d", c), 32'(dmem_req), 32'd0);
            chk($sformatf("trap.reg_we c%0d", c), 32'(reg_write_en), 32'd0);
            chk($sformatf("trap.pc_we c%0d", c), 32'(pc_write_en), 32'd0);
         end
         next_cyc();
      end
      chk("trap.instret", 32'(instret), 32'd0);
`else
      run_insn(v_ill, "illegal_as_add");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
